// File: rtl/word_serializer.sv
// Parallel-to-serial front end: buffers one SIZE-bit word behind a valid/ready
// handshake and streams words MSB-first, one bit per cycle, stallable by hold.
module word_serializer #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            hold,
  output logic            out,
  output logic            out_enable,
  output logic            out_last,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_next;
  logic [SIZE-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] bit_cnt, cnt_next;
  logic [SIZE-1:0] pend_data, pend_data_next;
  logic            pend_full, pend_full_next;
  logic            load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      pend_data <= '0;
      pend_full <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
      pend_data <= pend_data_next;
      pend_full <= pend_full_next;
    end
  end

  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    cnt_next       = bit_cnt;
    pend_data_next = pend_data;
    pend_full_next = pend_full;
    load           = 1'b0;

    // Accept needs an empty buffer and load needs a full one, so they never collide.
    if (in_valid && in_ready) begin
      pend_data_next = in_data;
      pend_full_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (pend_full) load = 1'b1;
      end
      SHIFT: begin
        if (!hold) begin
          if (bit_cnt == LAST) begin
            if (pend_full) load = 1'b1;
            else           state_next = IDLE;
          end else begin
            shift_next = shift_reg << 1;
            cnt_next   = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      shift_next     = pend_data;
      cnt_next       = '0;
      pend_full_next = 1'b0;
      state_next     = SHIFT;
    end
  end

  always_comb begin
    in_ready   = !pend_full && !reset;
    out        = (state == SHIFT) ? shift_reg[SIZE-1] : 1'b0;
    out_enable = (state == SHIFT) && !hold;
    out_last   = out_enable && (bit_cnt == LAST);
    busy       = (state == SHIFT) || pend_full;
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: handshake latency, streaming, hold and
// reset behaviour, with a downstream left-shift capture of the serial stream.
module tb_word_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       hold;
  logic       out;
  logic       out_enable;
  logic       out_last;
  logic       busy;

  int unsigned vectors;
  int unsigned miscompares;
  logic [7:0]  lsr;

  word_serializer #(.SIZE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .out        (out),
    .out_enable (out_enable),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  // One streaming cycle: expects a valid bit, captures it downstream, advances.
  task automatic bit_cycle(input string tag, input logic eb, input logic el);
    #1;
    chk1({tag, "_oe"}, out_enable, 1'b1);
    chk1({tag, "_out"}, out, eb);
    chk1({tag, "_last"}, out_last, el);
    if (out_enable) lsr = {lsr[6:0], out};
    cyc();
  endtask

  task automatic send_word(input string tag, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      bit_cycle(tag, w[7-i], i == 7);
    end
  endtask

  task automatic idle_check(input string tag);
    #1;
    chk1({tag, "_idle_oe"}, out_enable, 1'b0);
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk1({tag, "_idle_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] stream;
    vectors     = 0;
    miscompares = 0;
    lsr         = '0;
    reset       = 1'b1;
    in_valid    = 1'b1;
    in_data     = 8'h3C;
    hold        = 1'b0;

    // Reset held with in_valid high
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("rst_rdy", in_ready, 1'b0);
      chk1("rst_out", out, 1'b0);
      chk1("rst_oe", out_enable, 1'b0);
      chk1("rst_last", out_last, 1'b0);
      chk1("rst_busy", busy, 1'b0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    idle_check("rst_rel");

    // Single word A5, latency 2
    cyc();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk1("a5_rdy", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    #1;
    chk1("a5_lat_oe", out_enable, 1'b0);
    chk1("a5_lat_busy", busy, 1'b1);
    chk1("a5_lat_rdy", in_ready, 1'b0);
    cyc();
    lsr = '0;
    send_word("a5", 8'hA5);
    idle_check("a5");
    chk("a5_lsr", lsr, 8'hA5);

    // Back-to-back F0 then 0F
    cyc();
    in_valid = 1'b1;
    in_data  = 8'hF0;
    #1;
    cyc();
    in_valid = 1'b0;
    #1;
    cyc();
    stream = 16'hF00F;
    for (int j = 0; j < 16; j++) begin
      if (j == 0) begin
        in_valid = 1'b1;
        in_data  = 8'h0F;
      end else begin
        in_valid = 1'b0;
      end
      bit_cycle("b2b", stream[15-j], (j == 7) || (j == 15));
    end
    idle_check("b2b");

    // Hold three cycles while bit 4 of C3 is on out
    cyc();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    #1;
    cyc();
    in_valid = 1'b0;
    #1;
    cyc();
    bit_cycle("c3", 1'b1, 1'b0);
    bit_cycle("c3", 1'b1, 1'b0);
    bit_cycle("c3", 1'b0, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("c3_hold_oe", out_enable, 1'b0);
      chk1("c3_hold_out", out, 1'b0);
      chk1("c3_hold_busy", busy, 1'b1);
      cyc();
    end
    hold = 1'b0;
    bit_cycle("c3", 1'b0, 1'b0);
    bit_cycle("c3", 1'b0, 1'b0);
    bit_cycle("c3", 1'b0, 1'b0);
    bit_cycle("c3", 1'b1, 1'b0);
    bit_cycle("c3", 1'b1, 1'b1);
    idle_check("c3");

    // Hold on the last bit of 3D with 81 pending
    cyc();
    in_valid = 1'b1;
    in_data  = 8'h3D;
    #1;
    cyc();
    in_valid = 1'b0;
    #1;
    cyc();
    bit_cycle("3d", 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h81;
    bit_cycle("3d", 1'b0, 1'b0);
    in_valid = 1'b0;
    bit_cycle("3d", 1'b1, 1'b0);
    bit_cycle("3d", 1'b1, 1'b0);
    bit_cycle("3d", 1'b1, 1'b0);
    bit_cycle("3d", 1'b1, 1'b0);
    bit_cycle("3d", 1'b0, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk1("3d_hold_oe", out_enable, 1'b0);
      chk1("3d_hold_last", out_last, 1'b0);
      chk1("3d_hold_out", out, 1'b1);
      chk1("3d_hold_rdy", in_ready, 1'b0);
      cyc();
    end
    hold = 1'b0;
    bit_cycle("3d", 1'b1, 1'b1);
    lsr = '0;
    send_word("81", 8'h81);
    idle_check("81");
    chk("81_lsr", lsr, 8'h81);

    // Reset mid-word of FF with 55 pending, then 80
    cyc();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    #1;
    cyc();
    in_valid = 1'b0;
    #1;
    cyc();
    in_valid = 1'b1;
    in_data  = 8'h55;
    bit_cycle("ff", 1'b1, 1'b0);
    in_valid = 1'b0;
    bit_cycle("ff", 1'b1, 1'b0);
    bit_cycle("ff", 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk1("midrst_rdy", in_ready, 1'b0);
    cyc();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h80;
    #1;
    chk1("postrst_oe", out_enable, 1'b0);
    chk1("postrst_busy", busy, 1'b0);
    chk1("postrst_rdy", in_ready, 1'b1);
    cyc();
    in_valid = 1'b0;
    #1;
    chk1("80_lat_oe", out_enable, 1'b0);
    chk1("80_lat_busy", busy, 1'b1);
    cyc();
    lsr = '0;
    send_word("80", 8'h80);
    chk("80_lsr", lsr, 8'h80);
    for (int i = 0; i < 10; i++) begin
      idle_check("no55");
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
